// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm annunciator.
// Holds the FSM state encoding, the default timing constants (in ticks)
// and a helper that picks the first-out zone from the latched zone bits.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SOUNDING = 2'd1,
    ST_SILENCED = 2'd2
  } state_t;

  localparam int DEF_SIREN_TICKS  = 600;  // 30 s at a 50 ms tick
  localparam int DEF_STROBE_TICKS = 4;    // 2.5 Hz strobe at a 50 ms tick
  localparam int DEF_WARBLE_TICKS = 2;

  // One-hot of the lowest-index set bit (000 when no bit is set).
  function automatic logic [2:0] lowest_set(input logic [2:0] z);
    return z & (~z + 3'd1);
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Divide-by-N on tick with a toggling output.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset (count and phase to 0)
//   clear     synchronous clear: count to 0, phase to clear_val
//   clear_val phase value loaded by clear
//   en        tick enable; each enabled cycle counts one tick
//   phase     toggles after every N enabled ticks
module tick_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic clear_val,
  input  logic en,
  output logic phase
);

  localparam int W = (N < 2) ? 1 : $clog2(N + 1);
  localparam logic [W-1:0] LAST = (N < 1) ? '0 : W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      phase <= clear_val;
    end else if (en) begin
      if (cnt >= LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: drives a warbling siren for a limited time, a strobe
// lamp, and zone LEDs with the first-out zone flashing at the strobe rate.
// Ports:
//   iCLK          system clock, rising edge
//   iRST          synchronous active-high reset
//   tick          one-cycle timebase enable (nominally 50 ms)
//   siren_en      alarm condition present
//   strobe_en     strobe lamp request
//   zone_detected latched zone bits, bit0 = zone 1
//   ack           silence request level, acted on at its rising edge
//   siren_out     pulsed siren drive
//   strobe_out    strobe lamp drive
//   zone_led      zone indicators (first-out flashes, others steady)
//   silenced      high while silenced
//
// state       | meaning
// ST_IDLE     | no alarm, siren off, LEDs mirror zones
// ST_SOUNDING | siren warbling, run timer counting down
// ST_SILENCED | siren off after ack or timeout; a new zone re-arms it
module alarm_annunciator
  import alarm_pkg::*;
#(
  parameter int SIREN_TICKS  = DEF_SIREN_TICKS,
  parameter int STROBE_TICKS = DEF_STROBE_TICKS,
  parameter int WARBLE_TICKS = DEF_WARBLE_TICKS
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       tick,
  input  logic       siren_en,
  input  logic       strobe_en,
  input  logic [2:0] zone_detected,
  input  logic       ack,
  output logic       siren_out,
  output logic       strobe_out,
  output logic [2:0] zone_led,
  output logic       silenced
);

  localparam int TW = (SIREN_TICKS < 2) ? 1 : $clog2(SIREN_TICKS + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(SIREN_TICKS);

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    first_out, first_out_nx;
  logic [2:0]    snapshot, snapshot_nx;
  logic [2:0]    zone_q;
  logic          ack_q;
  logic          ack_rise, new_zone, expire, enter_sounding;
  logic          warble_clear;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= ST_IDLE;
      timer     <= '0;
      first_out <= '0;
      snapshot  <= '0;
      zone_q    <= '0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      first_out <= first_out_nx;
      snapshot  <= snapshot_nx;
      zone_q    <= zone_detected;
      ack_q     <= ack;
    end
  end

  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    first_out_nx = first_out;
    snapshot_nx  = snapshot;
    ack_rise     = ack & ~ack_q;
    new_zone     = |(zone_detected & ~snapshot);
    // Expiry is judged on the pre-decrement value so the timer never wraps.
    expire       = tick && (timer <= TW'(1));

    if (!siren_en) begin
      state_nx     = ST_IDLE;
      timer_nx     = '0;
      first_out_nx = '0;
      snapshot_nx  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx     = ST_SOUNDING;
          timer_nx     = TIMER_LOAD;
          first_out_nx = lowest_set(zone_detected);
          snapshot_nx  = zone_detected;
        end
        ST_SOUNDING: begin
          // A fresh zone restarts the run time and beats a same-cycle ack.
          if (new_zone) begin
            timer_nx    = TIMER_LOAD;
            snapshot_nx = zone_detected;
          end else if (ack_rise || expire) begin
            state_nx = ST_SILENCED;
            timer_nx = '0;
          end else if (tick) begin
            timer_nx = timer - TW'(1);
          end
        end
        ST_SILENCED: begin
          if (new_zone) begin
            state_nx    = ST_SOUNDING;
            timer_nx    = TIMER_LOAD;
            snapshot_nx = zone_detected;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end

    enter_sounding = (state != ST_SOUNDING) && (state_nx == ST_SOUNDING);
    // Warble phase restarts high on entry and is held low whenever not sounding,
    // so its register doubles as the siren drive.
    warble_clear   = (state_nx != ST_SOUNDING) || enter_sounding;
  end

  tick_counter #(.N(WARBLE_TICKS)) u_warble (
    .clk       (iCLK),
    .rst       (iRST),
    .clear     (warble_clear),
    .clear_val (enter_sounding),
    .en        (tick),
    .phase     (siren_out)
  );

  tick_counter #(.N(STROBE_TICKS)) u_strobe (
    .clk       (iCLK),
    .rst       (iRST),
    .clear     (~strobe_en),
    .clear_val (1'b0),
    .en        (tick),
    .phase     (strobe_out)
  );

  // first_out is only ever non-zero while siren_en was high at the last edge,
  // so it also carries the siren_en qualification for the flashing LED.
  assign zone_led = (first_out & {3{strobe_out}}) | (~first_out & zone_q);
  assign silenced = (state == ST_SILENCED);

endmodule

// File: tb/tb_alarm_annunciator.sv
module tb_alarm_annunciator;

  localparam int SIREN  = 6;
  localparam int STROBE = 4;
  localparam int WARBLE = 2;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       tick = 1'b0;
  logic       siren_en = 1'b0;
  logic       strobe_en = 1'b0;
  logic [2:0] zone_detected = 3'b000;
  logic       ack = 1'b0;
  logic       siren_out, strobe_out, silenced;
  logic [2:0] zone_led;

  int tests = 0;
  int fails = 0;

  alarm_annunciator #(
    .SIREN_TICKS (SIREN),
    .STROBE_TICKS(STROBE),
    .WARBLE_TICKS(WARBLE)
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .tick         (tick),
    .siren_en     (siren_en),
    .strobe_en    (strobe_en),
    .zone_detected(zone_detected),
    .ack          (ack),
    .siren_out    (siren_out),
    .strobe_out   (strobe_out),
    .zone_led     (zone_led),
    .silenced     (silenced)
  );

  always #5 iCLK = ~iCLK;

  // Reference model: mode 0 idle, 1 sounding, 2 silenced. Timing is kept as
  // elapsed tick counts and outputs are derived arithmetically from them.
  int         m_mode = 0;
  int         m_since_entry = 0;
  int         m_since_reload = 0;
  int         m_strobe_ticks = 0;
  logic [2:0] m_first = 3'b000;
  logic [2:0] m_snap = 3'b000;
  logic [2:0] m_zone_prev = 3'b000;
  logic       m_ack_prev = 1'b0;
  logic       m_siren_prev = 1'b0;

  task automatic model_step(input logic r, input logic t, input logic se,
                            input logic sten, input logic [2:0] z, input logic a);
    logic rise, newz;
    if (r) begin
      m_mode = 0; m_since_entry = 0; m_since_reload = 0; m_strobe_ticks = 0;
      m_first = 3'b000; m_snap = 3'b000; m_zone_prev = 3'b000;
      m_ack_prev = 1'b0; m_siren_prev = 1'b0;
      return;
    end
    if (!sten) m_strobe_ticks = 0;
    else if (t) m_strobe_ticks++;
    rise = a && !m_ack_prev;
    newz = |(z & ~m_snap);
    if (!se) begin
      m_mode = 0; m_first = 3'b000; m_snap = 3'b000;
    end else if (m_mode == 0) begin
      m_mode = 1; m_since_entry = 0; m_since_reload = 0; m_snap = z;
      m_first = 3'b000;
      for (int i = 0; i < 3; i++)
        if (z[i] && m_first == 3'b000) m_first[i] = 1'b1;
    end else if (m_mode == 1) begin
      if (newz) begin
        m_snap = z; m_since_reload = 0;
        if (t) m_since_entry++;
      end else if (rise || (t && (SIREN - m_since_reload) <= 1)) begin
        m_mode = 2;
      end else if (t) begin
        m_since_entry++; m_since_reload++;
      end
    end else if (newz) begin
      m_mode = 1; m_since_entry = 0; m_since_reload = 0; m_snap = z;
    end
    m_ack_prev = a; m_zone_prev = z; m_siren_prev = se;
  endtask

  function automatic logic [5:0] model_out();
    logic s, st, sil;
    logic [2:0] led;
    s   = (m_mode == 1) && (((m_since_entry / WARBLE) % 2) == 0);
    st  = ((m_strobe_ticks / STROBE) % 2) == 1;
    sil = (m_mode == 2);
    for (int i = 0; i < 3; i++)
      led[i] = (m_first[i] && m_siren_prev) ? st : m_zone_prev[i];
    return {s, st, led, sil};
  endfunction

  function automatic logic [5:0] outs();
    return {siren_out, strobe_out, zone_led, silenced};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic t, input logic se,
                       input logic sten, input logic [2:0] z, input logic a);
    iRST = r; tick = t; siren_en = se; strobe_en = sten; zone_detected = z; ack = a;
    model_step(r, t, se, sten, z, a);
    @(posedge iCLK);
    #1;
    check("model", int'(outs()), int'(model_out()));
  endtask

  // Ticks every cycle until silenced rises; returns ticks taken (bounded).
  task automatic ticks_to_silence(input logic sten, input logic [2:0] z, output int n);
    n = 0;
    while (!silenced && n < 40) begin
      cycle(1'b0, 1'b1, 1'b1, sten, z, 1'b0);
      n++;
    end
  endtask

  typedef struct {
    logic       rst, tk, se, sten;
    logic [2:0] z;
    logic       a;
    logic [5:0] exp;  // {siren, strobe, zone_led[2:0], silenced}
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n;
    logic r, t, se, sten, a;
    logic [2:0] z, one;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 6'b0_0_000_0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 6'b1_0_000_0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 6'b1_0_000_0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 6'b0_0_000_0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 6'b0_0_000_0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 6'b1_1_010_0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 6'b1_1_010_0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 6'b0_1_010_1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 6'b0_1_010_1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 6'b0_0_000_1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0, 6'b1_0_100_0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b1, 6'b0_0_100_1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b1, 6'b0_0_100_1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 6'b0_0_100_1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 6'b0_0_110_0};

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].rst, vecs[i].tk, vecs[i].se, vecs[i].sten, vecs[i].z, vecs[i].a);
      check($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
    end

    // Strobe drop mid-period, then a full half-period after re-enable.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    check("strobe_drop", int'(strobe_out), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    check("strobe_restart_3", int'(strobe_out), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    check("strobe_restart_4", int'(strobe_out), 1);

    // siren_en falling together with an ack rising edge.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    check("enter_sounding", int'(siren_out), 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1);
    check("drop_and_ack", int'(outs()), int'(6'b0_0_001_0));

    // Reset during sounding with a tick, then re-entry with a full timer.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0);
    check("reset_mid_sounding", int'(outs()), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    check("reenter_after_reset", int'({siren_out, silenced}), 2);
    ticks_to_silence(1'b0, 3'b001, n);
    check("timer_after_reset", n, SIREN);

    // New zone while silenced reloads the timer; first-out is kept.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0);
    ticks_to_silence(1'b1, 3'b010, n);
    check("timer_first_run", n, SIREN);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 3'b110, 1'b0);
    check("rearm_state", int'({siren_out, silenced, zone_led[2]}), 3'b101);
    check("rearm_first_out", int'(zone_led[1]), int'(strobe_out));
    ticks_to_silence(1'b1, 3'b110, n);
    check("timer_reloaded", n, SIREN);

    // Randomised traffic against the model.
    se = 1'b0; sten = 1'b0; z = 3'b000; a = 1'b0; one = 3'b001;
    for (int k = 0; k < 4000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) se = ~se;
      if ($urandom_range(0, 39) == 0) sten = ~sten;
      if (!se) z = 3'b000;
      else if ($urandom_range(0, 29) == 0) z = z | (one << $urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) a = ~a;
      cycle(r, t, se, sten, z, a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_annunciator.md
ALARM_ANNUNCIATOR -- requirements
Module: alarm_annunciator

Interface
REQ-001 SHALL have parameter SIREN_TICKS, default 600, siren run time in ticks (30 s at 50 ms tick).
REQ-002 SHALL have parameter STROBE_TICKS, default 4, ticks per strobe half-period (2.5 Hz at 50 ms tick).
REQ-003 SHALL have parameter WARBLE_TICKS, default 2, ticks per siren on/off half-period.
REQ-004 iCLK  input  1  single system clock; all logic on rising edge.
REQ-005 iRST  input  1  reset, synchronous, active-high.
REQ-006 tick  input  1  one-iCLK-cycle enable strobe, nominally every 50 ms.
REQ-007 siren_en  input  1  alarm condition from state machine (triggered or panic).
REQ-008 strobe_en  input  1  strobe request from state machine.
REQ-009 zone_detected  input  3  latched zone bits, bit0 = zone 1.
REQ-010 ack  input  1  debounced silence request, level; acted on at its rising edge.
REQ-011 siren_out  output  1  pulsed siren drive.
REQ-012 strobe_out  output  1  strobe lamp drive.
REQ-013 zone_led  output  3  zone indicators; first-out zone flashes, others steady.
REQ-014 silenced  output  1  high while in SILENCED.

Function
REQ-015 SHALL implement FSM states IDLE, SOUNDING, SILENCED.
REQ-016 IDLE: siren_out=0, zone_led=zone_detected, silenced=0; siren_en high -> SOUNDING next cycle.
REQ-017 Entry to SOUNDING SHALL load siren timer with SIREN_TICKS and reset warble counter and warble phase to 1.
REQ-018 Entry to SOUNDING from IDLE SHALL capture first_out = one-hot of lowest-index set bit of zone_detected (000 if none) and snapshot = zone_detected.
REQ-019 SOUNDING: siren_out = warble phase; warble phase toggles every WARBLE_TICKS ticks; timer decrements by 1 per tick.
REQ-020 SOUNDING: timer reaching 0 on a tick, or ack rising edge -> SILENCED next cycle.
REQ-021 SILENCED: siren_out=0, silenced=1; strobe continues.
REQ-022 SILENCED: any zone_detected bit set that is clear in snapshot -> SOUNDING (reload timer, snapshot updated, first_out unchanged).
REQ-023 Any state: siren_en low -> IDLE next cycle; first_out and snapshot cleared.
REQ-024 Priority in one cycle: siren_en low > new zone > ack/timer expiry.
REQ-025 strobe_out SHALL toggle every STROBE_TICKS ticks while strobe_en high; forced 0 and counter cleared when strobe_en low, independent of FSM state.
REQ-026 zone_led[i] = strobe phase when first_out[i]=1 and siren_en high, else zone_detected[i].
REQ-027 Counters SHALL be sized $clog2(param+1) bits; no wrap below 0; tick absent -> counters hold.
REQ-028 Output latency from any input change SHALL be exactly one iCLK cycle (registered outputs).

Reset
REQ-029 iRST high SHALL force state IDLE and, on the next edge, siren_out=0, strobe_out=0, zone_led=000, silenced=0, all counters/first_out/snapshot/ack-edge register 0.
REQ-030 iRST mid-SOUNDING SHALL take priority over every other input, including tick.

Structure
REQ-031 State encoding and default timing constants SHALL live in shared package alarm_pkg.
REQ-032 One sub-module tick_counter (parameterised divide-by-N on tick, toggle output, synchronous clear) SHALL be instantiated for strobe and warble.

Verification
REQ-033 siren_en=1, zone_detected=010, SIREN_TICKS=6, 10 ticks -> siren_out toggles every 2 ticks for 6 ticks, then silenced=1, siren_out=0; zone_led[1] flashes.
REQ-034 SOUNDING, ack rising at tick 3 -> SILENCED next cycle, siren_out=0, strobe_out still toggling every 4 ticks.
REQ-035 SILENCED, zone_detected 010->110 -> SOUNDING, timer reloaded to SIREN_TICKS, zone_led[1] still flashes, zone_led[2]=1 steady.
REQ-036 Same cycle siren_en 1->0 and ack rising -> IDLE, siren_out=0, silenced=0.
REQ-037 iRST=1 during SOUNDING with tick=1 -> all outputs 0 next edge; siren_en held 1 and iRST released -> SOUNDING re-entered, timer = SIREN_TICKS.
REQ-038 strobe_en=1 then 0 mid-period -> strobe_out=0 next cycle; re-enable restarts full 4-tick half-period.
